frame_rd_addr_gen: RTL and testbench
====================================

# frame_rd_addr_gen

DDR read-side frame address generator: the consumer of the `rd_bank`/`rd_load` bank-load handshake and the producer of `frame_rd_done` back to the bank ping-pong controller. On each load it latches the selected bank and issues one full frame of fixed-length DDR read bursts. Bursts are throttled by the occupancy of the downstream read FIFO. When the last burst's data has returned, it pulses `frame_rd_done`. It sits between the bank switch controller and the DDR user read port, in the `phy_clk` domain.

## Interface
- `ADDR_W`, 25: DDR word-address width; bank is `[ADDR_W-1:ADDR_W-2]`.
- `BURST_LEN`, 64: words per read burst; power of two.
- `FRAME_BURSTS`, 4800: bursts per frame.
- `FIFO_DEPTH`, 512: downstream read FIFO depth in words.
- `CNT_W`, 10: width of the FIFO occupancy count.

Ports:
- `phy_clk`  in  1  sole clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `rd_bank`  in  2  bank to read; sampled only with `rd_load`.
- `rd_load`  in  1  one-cycle request to start a frame read.
- `fifo_wr_cnt`  in  CNT_W  current downstream FIFO occupancy in words.
- `ddr_rd_req`  out  1  burst request; held until acknowledged.
- `ddr_rd_addr`  out  ADDR_W  burst start address.
- `ddr_rd_ack`  in  1  request accepted by the DDR controller.
- `ddr_rd_done`  in  1  one-cycle pulse when the burst's last word has been written into the FIFO.
- `frame_rd_done`  out  1  one-cycle pulse when the frame is complete.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: on `rd_load`, latch `rd_bank`, clear `burst_cnt` and offset, then go to CHECK.
  - CHECK: if `fifo_wr_cnt <= FIFO_DEPTH - BURST_LEN`, go to REQ; otherwise stay.
  - REQ: `ddr_rd_req` = 1. On `ddr_rd_ack`, go to WAIT_DATA.
  - WAIT_DATA: on `ddr_rd_done`, add `BURST_LEN` to the offset and increment `burst_cnt`. If `burst_cnt == FRAME_BURSTS-1` (pre-increment), go to DONE; otherwise go to CHECK.
  - DONE: `frame_rd_done` = 1 for one cycle, then go to IDLE.
- Address: `ddr_rd_addr = {bank_q, offset}`, where the offset is `ADDR_W-2` bits and counts `burst_cnt*BURST_LEN`.
- Elaboration error if `FRAME_BURSTS*BURST_LEN > 2**(ADDR_W-2)`. As a result, the offset never wraps into the bank bits.
- `rd_load` outside IDLE is ignored; the bank and sequence are unchanged.
- `ddr_rd_done` outside WAIT_DATA is ignored. `ddr_rd_ack` outside REQ is ignored.
- One outstanding burst at most.

## Timing
- Reset values: `ddr_rd_req` 0, `ddr_rd_addr` 0, `frame_rd_done` 0, `busy` 0, state IDLE, `bank_q` 0, counters 0.
- All outputs are registered.
- `rd_load` sampled at edge N:
  - `busy` = 1 after edge N.
  - `ddr_rd_req` = 1 after edge N+1, if the FIFO has room.
- `ddr_rd_addr` is valid from the cycle `ddr_rd_req` rises and stays stable until the ack edge.
- `ddr_rd_req` falls the cycle after `ddr_rd_ack` is sampled.
- `ddr_rd_done` sampled at edge M in WAIT_DATA:
  - Next burst: next `ddr_rd_req` no earlier than after edge M+1.
  - Last burst: `frame_rd_done` high after edge M+1, low after edge M+2; `busy` low after edge M+2.
- Back-to-back frames: `rd_load` is accepted in the first IDLE cycle after `frame_rd_done`.
- Reset mid-frame: immediate return to reset values; no `frame_rd_done` is emitted.

## Configuration
- `FRAME_RD_ERR_EN` defined:
  - Adds output `rd_load_err` (1 bit, reset 0).
  - Set sticky when `rd_load` is sampled in any non-IDLE state; cleared only by `sys_rst`.
- Undefined: the port is absent and such loads are silently dropped.

## Structure
- Package `frame_rd_pkg` holds:
  - the state enum (IDLE, CHECK, REQ, WAIT_DATA, DONE);
  - the bank-field position constants;
  - the `BANK_W = 2` constant.
- Single module; no sub-module is needed.

## Test plan
All scenarios use `BURST_LEN=64`, `FRAME_BURSTS=4`, `FIFO_DEPTH=512`.
- **Basic frame:** `rd_load` with `rd_bank=2'b10`, FIFO empty, ack immediate, `ddr_rd_done` 3 cycles after ack -> addresses 0x1000000, 0x1000040, 0x1000080, 0x10000C0, then exactly one `frame_rd_done` pulse one cycle after the 4th done.
- **FIFO throttling:** `fifo_wr_cnt=460` -> no request. Drop to 448 -> `ddr_rd_req` rises one cycle later.
- **Delayed ack:** ack held off 5 cycles -> `ddr_rd_req` and `ddr_rd_addr` stable throughout, and exactly one burst is counted.
- **Load while busy:** `rd_load` with `rd_bank=2'b01` mid-frame -> address sequence unchanged. With `FRAME_RD_ERR_EN`, `rd_load_err`=1 and stays high.
- **Reset mid-frame:** `sys_rst` after 2 bursts -> all outputs 0 and no `frame_rd_done`. A following `rd_load` with `rd_bank=2'b11` starts at 0x1800000.
- **Back-to-back frames:** `rd_load` in the cycle after `frame_rd_done` -> accepted; the new frame starts at offset 0.

Source files
------------

// File: rtl/frame_rd_pkg.sv
// frame_rd_pkg: shared types and constants for the frame read address generator.
//   state_t     - read sequencer states
//   BANK_W      - width of the DDR bank field at the top of the word address
//   BANK_HI_OFS - distance of the bank field MSB below ADDR_W
//   BANK_LO_OFS - distance of the bank field LSB below ADDR_W
package frame_rd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    WAIT_DATA,
    DONE
  } state_t;

  localparam int BANK_W      = 2;
  localparam int BANK_HI_OFS = 1;
  localparam int BANK_LO_OFS = BANK_W;

endpackage

// File: rtl/frame_rd_addr_gen.sv
// frame_rd_addr_gen: DDR read-side frame address generator (phy_clk domain).
// On rd_load it latches rd_bank and issues FRAME_BURSTS read bursts of
// BURST_LEN words each. A burst is issued only when the downstream FIFO has
// room for a full burst. frame_rd_done pulses after the last burst's data
// has landed in the FIFO.
//
// Ports:
//   phy_clk, sys_rst       clock, asynchronous active-high reset
//   rd_bank, rd_load       frame start request (bank sampled with the load)
//   fifo_wr_cnt            downstream FIFO occupancy in words
//   ddr_rd_req/addr/ack    burst request handshake to the DDR controller
//   ddr_rd_done            last word of the outstanding burst written
//   frame_rd_done          one-cycle frame-complete pulse
//   busy                   sequencer is not idle
//   rd_load_err            (only with FRAME_RD_ERR_EN) sticky flag: rd_load
//                          arrived while a frame was in progress
//
// Optional feature macro: FRAME_RD_ERR_EN.
module frame_rd_addr_gen
  import frame_rd_pkg::*;
#(
  parameter int ADDR_W       = 25,
  parameter int BURST_LEN    = 64,
  parameter int FRAME_BURSTS = 4800,
  parameter int FIFO_DEPTH   = 512,
  parameter int CNT_W        = 10
) (
  input  logic              phy_clk,
  input  logic              sys_rst,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic              rd_load,
  input  logic [CNT_W-1:0]  fifo_wr_cnt,
  output logic              ddr_rd_req,
  output logic [ADDR_W-1:0] ddr_rd_addr,
  input  logic              ddr_rd_ack,
  input  logic              ddr_rd_done,
  output logic              frame_rd_done,
  output logic              busy
`ifdef FRAME_RD_ERR_EN
  ,
  output logic              rd_load_err
`endif
);

  localparam int BANK_HI = ADDR_W - BANK_HI_OFS;
  localparam int BANK_LO = ADDR_W - BANK_LO_OFS;
  localparam int OFS_W   = BANK_LO;
  localparam int BC_W    = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

  // Highest occupancy that still leaves room for one whole burst.
  localparam logic [CNT_W:0] ROOM_MAX = (CNT_W+1)'(FIFO_DEPTH - BURST_LEN);

  // A frame must fit inside one bank so the offset never spills into the
  // bank bits.
  if (longint'(FRAME_BURSTS) * longint'(BURST_LEN) > (longint'(1) << OFS_W)) begin : g_frame_too_big
    $error("frame_rd_addr_gen: FRAME_BURSTS*BURST_LEN exceeds one bank");
  end
  if ((BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_burst_not_pow2
    $error("frame_rd_addr_gen: BURST_LEN must be a power of two");
  end

  state_t            state;
  logic [BANK_W-1:0] bank_q;
  logic [OFS_W-1:0]  offset;
  logic [BC_W-1:0]   burst_cnt;
  logic              room;

  assign room = ({1'b0, fifo_wr_cnt} <= ROOM_MAX);

  always_ff @(posedge phy_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= IDLE;
      bank_q        <= '0;
      offset        <= '0;
      burst_cnt     <= '0;
      ddr_rd_req    <= 1'b0;
      ddr_rd_addr   <= '0;
      frame_rd_done <= 1'b0;
      busy          <= 1'b0;
`ifdef FRAME_RD_ERR_EN
      rd_load_err   <= 1'b0;
`endif
    end else begin
`ifdef FRAME_RD_ERR_EN
      if (rd_load && state != IDLE) rd_load_err <= 1'b1;
`endif
      unique case (state)
        IDLE: begin
          if (rd_load) begin
            bank_q    <= rd_bank;
            offset    <= '0;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (room) begin
            ddr_rd_req                    <= 1'b1;
            ddr_rd_addr[BANK_HI:BANK_LO]  <= bank_q;
            ddr_rd_addr[BANK_LO-1:0]      <= offset;
            state                         <= REQ;
          end
        end
        REQ: begin
          if (ddr_rd_ack) begin
            ddr_rd_req <= 1'b0;
            state      <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (ddr_rd_done) begin
            offset    <= offset + OFS_W'(BURST_LEN);
            burst_cnt <= burst_cnt + 1'b1;
            state     <= (burst_cnt == BC_W'(FRAME_BURSTS - 1)) ? DONE : CHECK;
          end
        end
        DONE: begin
          // Two cycles here: first raises the registered pulse, second
          // drops it together with busy so both fall on the same edge.
          if (!frame_rd_done) begin
            frame_rd_done <= 1'b1;
          end else begin
            frame_rd_done <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_rd_addr_gen.sv
// Self-checking bench for frame_rd_addr_gen with BURST_LEN=64,
// FRAME_BURSTS=4, FIFO_DEPTH=512. A transaction-level model tracks the
// expected outputs every cycle; directed scenarios pin addresses and pulse
// counts with literal values.
module tb_frame_rd_addr_gen;

  localparam int ADDR_W = 25;
  localparam int BL     = 64;
  localparam int FB     = 4;
  localparam int DEPTH  = 512;
  localparam int CNT_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        rd_bank;
  logic              rd_load;
  logic [CNT_W-1:0]  fifo_wr_cnt;
  logic              ddr_rd_req;
  logic [ADDR_W-1:0] ddr_rd_addr;
  logic              ddr_rd_ack;
  logic              ddr_rd_done;
  logic              frame_rd_done;
  logic              busy;
`ifdef FRAME_RD_ERR_EN
  logic              rd_load_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int fd_cnt = 0;

  frame_rd_addr_gen #(
    .ADDR_W(ADDR_W), .BURST_LEN(BL), .FRAME_BURSTS(FB),
    .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .phy_clk(clk), .sys_rst(rst), .rd_bank(rd_bank), .rd_load(rd_load),
    .fifo_wr_cnt(fifo_wr_cnt), .ddr_rd_req(ddr_rd_req),
    .ddr_rd_addr(ddr_rd_addr), .ddr_rd_ack(ddr_rd_ack),
    .ddr_rd_done(ddr_rd_done), .frame_rd_done(frame_rd_done), .busy(busy)
`ifdef FRAME_RD_ERR_EN
    , .rd_load_err(rd_load_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks the frame as a count of returned bursts plus "what we are
  // waiting for" flags; the expected address is bank * bank_size +
  // returned_bursts * BL.
  logic              m_busy, m_req, m_fd, m_chk, m_wait, m_err;
  logic [ADDR_W-1:0] m_addr;
  logic [1:0]        m_bank;
  int                m_ret, m_fin;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_req <= 0; m_fd <= 0; m_chk <= 0; m_wait <= 0; m_err <= 0;
      m_addr <= '0; m_bank <= '0; m_ret <= 0; m_fin <= 0;
    end else begin
      if (m_busy && rd_load) m_err <= 1;
      if (!m_busy && rd_load) begin
        m_bank <= rd_bank; m_busy <= 1; m_ret <= 0; m_chk <= 1;
      end else if (m_chk && int'(fifo_wr_cnt) <= DEPTH - BL) begin
        m_req  <= 1;
        m_addr <= ADDR_W'(m_bank) * (ADDR_W'(1) << (ADDR_W - 2)) + ADDR_W'(m_ret * BL);
        m_chk  <= 0;
      end else if (m_req && ddr_rd_ack) begin
        m_req <= 0; m_wait <= 1;
      end else if (m_wait && ddr_rd_done) begin
        m_wait <= 0; m_ret <= m_ret + 1;
        if (m_ret + 1 == FB) m_fin <= 2; else m_chk <= 1;
      end else if (m_fin == 2) begin
        m_fd <= 1; m_fin <= 1;
      end else if (m_fin == 1) begin
        m_fd <= 0; m_busy <= 0; m_fin <= 0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("req", 32'(ddr_rd_req), 32'(m_req));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_rd_done", 32'(frame_rd_done), 32'(m_fd));
    if (m_req) chk("addr", 32'(ddr_rd_addr), 32'(m_addr));
`ifdef FRAME_RD_ERR_EN
    chk("rd_load_err", 32'(rd_load_err), 32'(m_err));
`endif
    if (frame_rd_done) fd_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_req(output logic ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (ddr_rd_req) ok = 1;
    end
    if (!ok) chk("req_timeout", 0, 1);
  endtask

  task automatic load(input logic [1:0] b);
    @(negedge clk); rd_load = 1; rd_bank = b;
    @(negedge clk); rd_load = 0;
  endtask

  // One burst: wait for the request, check the literal start address,
  // hold the ack off, then return data done_dly cycles after the ack.
  task automatic serve(input logic [31:0] exp_addr, input int ack_dly, input int done_dly);
    logic ok;
    wait_req(ok);
    if (!ok) return;
    chk("burst_addr", 32'(ddr_rd_addr), exp_addr);
    repeat (ack_dly) begin
      @(negedge clk);
      chk("req_held", 32'(ddr_rd_req), 1);
      chk("addr_held", 32'(ddr_rd_addr), exp_addr);
    end
    ddr_rd_ack = 1; @(negedge clk); ddr_rd_ack = 0;
    repeat (done_dly - 1) @(negedge clk);
    ddr_rd_done = 1; @(negedge clk); ddr_rd_done = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, 32'(ddr_rd_req), 0);
    chk({tag, "_addr"}, 32'(ddr_rd_addr), 0);
    chk({tag, "_fd"}, 32'(frame_rd_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
`ifdef FRAME_RD_ERR_EN
    chk({tag, "_err"}, 32'(rd_load_err), 0);
`endif
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    logic ok;
    rst = 1; rd_bank = 0; rd_load = 0; fifo_wr_cnt = 0;
    ddr_rd_ack = 0; ddr_rd_done = 0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 0;

    // Basic frame, bank 2.
    load(2'b10);
    chk("busy_after_load", 32'(busy), 1);
    for (int i = 0; i < FB; i++) serve(32'h100_0000 + 32'(i * 64), 0, 3);
    repeat (5) @(negedge clk);
    chk("basic_fd_cnt", 32'(fd_cnt), 1);
    chk("basic_idle", 32'(busy), 0);

    // Throttling, delayed ack, load while busy, bank 0.
    fifo_wr_cnt = 460;
    load(2'b00);
    repeat (4) begin
      @(negedge clk);
      chk("throttle_no_req", 32'(ddr_rd_req), 0);
    end
    fifo_wr_cnt = 448;
    @(negedge clk);
    chk("req_after_room", 32'(ddr_rd_req), 1);
    serve(32'h000_0000, 5, 2);
    rd_load = 1; rd_bank = 2'b01;
    @(negedge clk); rd_load = 0;
    serve(32'h000_0040, 0, 2);
    serve(32'h000_0080, 0, 2);
    serve(32'h000_00C0, 0, 2);
    repeat (5) @(negedge clk);
    chk("throttle_fd_cnt", 32'(fd_cnt), 2);
`ifdef FRAME_RD_ERR_EN
    chk("err_sticky", 32'(rd_load_err), 1);
`endif

    // Reset mid-frame after two bursts.
    fifo_wr_cnt = 0;
    load(2'b10);
    serve(32'h100_0000, 0, 2);
    serve(32'h100_0040, 0, 2);
    wait_req(ok);
    rst = 1;
    @(negedge clk);
    chk_idle_outputs("midrst");
    rst = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_fd", 32'(fd_cnt), 2);
    load(2'b11);
    for (int i = 0; i < FB; i++) serve(32'h180_0000 + 32'(i * 64), 0, 2);

    // Back-to-back: load in the cycle right after frame_rd_done.
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (frame_rd_done) ok = 1;
    end
    chk("b2b_fd_seen", 32'(ok), 1);
    @(negedge clk); rd_load = 1; rd_bank = 2'b01;
    @(negedge clk); rd_load = 0;
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_fd_cnt", 32'(fd_cnt), 3);
    for (int i = 0; i < FB; i++) serve(32'h080_0000 + 32'(i * 64), 1, 1);
    repeat (5) @(negedge clk);
    chk("final_fd_cnt", 32'(fd_cnt), 4);
    chk("final_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
